uart_tx_sched: RTL and testbench

Transmit-side controller for the shared UART core. It arbitrates byte writes from two requesters, the CPU bus port (req0) and the debug monitor (req1), into a shared TX FIFO. It then sequences each byte into the UART core's `tx_data`/`tx_en`/`tx_busy` handshake, so neither requester has to poll `tx_busy`. It sits between the bus-side UART wrapper logic and the UART core, entirely in the `clk_50` domain.

---
 rtl/uart_tx_sched.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module      : uart_tx_sched
// Description : Two-requester round-robin arbiter feeding a TX FIFO, plus a
//               sequencer driving the UART core tx_data/tx_en/tx_busy handshake.
//               Optional WAIT timeout enabled by UART_TX_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_sched #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk_50,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       req0_valid,
  input  logic [7:0]                 req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [7:0]                 req1_data,
  output logic                       req1_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_en,
  input  logic                       tx_busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic                       timeout_err
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam logic [c_addr_w:0] c_full_count = (c_addr_w + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_TRANSMIT = 2'd2
  } state_t;

  logic [7:0]          r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w:0]   r_count;
  logic                r_rr;
  state_t              r_state;

  logic       w_can_push;
  logic       w_push0;
  logic       w_push1;
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_push_data;

  assign fifo_count = r_count;
  assign fifo_empty = (r_count == '0);
  assign fifo_full  = (r_count == c_full_count);

  // r_rr == 1 means req1 wins a tie; it names the requester not granted last.
  assign w_can_push  = !fifo_full && !flush;
  assign req0_ready  = w_can_push && (!req1_valid || !r_rr);
  assign req1_ready  = w_can_push && (!req0_valid || r_rr);
  assign w_push0     = req0_valid && req0_ready;
  assign w_push1     = req1_valid && req1_ready;
  assign w_push      = w_push0 || w_push1;
  assign w_push_data = w_push1 ? req1_data : req0_data;
  assign w_pop       = (r_state == ST_IDLE) && !fifo_empty;

  always_ff @(posedge clk_50) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr     <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr     <= w_push0;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int c_timer_w = $clog2(TIMEOUT + 1);
  localparam logic [c_timer_w-1:0] c_timer_max = c_timer_w'(TIMEOUT - 1);

  logic [c_timer_w-1:0] r_timer;
  logic                 r_timeout_err;

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state <= ST_IDLE;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      r_timer       <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
      if (flush) begin
        r_timeout_err <= 1'b0;
      end
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            tx_data <= r_mem[r_rd_ptr];
            tx_en   <= 1'b1;
            r_state <= ST_WAIT;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            r_timer <= '0;
`endif
          end
        end
        ST_WAIT: begin
          // tx_busy takes priority over an expiring timer.
          if (tx_busy) begin
            tx_en   <= 1'b0;
            r_state <= ST_TRANSMIT;
          end
`ifdef UART_TX_SCHED_TIMEOUT_EN
          else if (r_timer == c_timer_max) begin
            tx_en         <= 1'b0;
            r_state       <= ST_IDLE;
            r_timeout_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
`endif
        end
        ST_TRANSMIT: begin
          if (!tx_busy) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          tx_en   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Directed self-checking bench for uart_tx_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_sched;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic       flush;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_busy;
  logic [3:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_sched #(.DEPTH(8), .TIMEOUT(16)) dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .flush       (flush),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_busy     (tx_busy),
    .fifo_count  (fifo_count),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .timeout_err (timeout_err)
  );

  always #10 clk_50 = ~clk_50;

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_50);
    reset = 1'b0;
    @(negedge clk_50);
  endtask

  // Acts as the UART core for one byte: returns the byte seen with tx_en high.
  task automatic serve_byte(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'h00;
    for (int i = 0; i < 50; i++) begin
      if (tx_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_50);
    end
    if (ok) begin
      d       = tx_data;
      tx_busy = 1'b1;
      repeat (4) @(negedge clk_50);
      tx_busy = 1'b0;
      @(negedge clk_50);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; tx_busy = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
    repeat (3) @(negedge clk_50);
    reset = 1'b0;
    @(negedge clk_50);
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en got %b exp 0", tx_en); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", fifo_full); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL reset_rr_req0 got %b exp 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_rr_req1 got %b exp 0", req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_data = 8'h41;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", req0_ready); end
    @(negedge clk_50);
    req0_valid = 1'b0;
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count1 got %0d exp 1", fifo_count); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL single_en_early got %b exp 0", tx_en); end
    @(negedge clk_50);
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL single_en got %b exp 1", tx_en); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data got %h exp 41", tx_data); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count0 got %0d exp 0", fifo_count); end
    repeat (2) @(negedge clk_50);
    tx_busy = 1'b1;
    @(negedge clk_50);
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL single_en_drop got %b exp 0", tx_en); end
    repeat (159) @(negedge clk_50);
    tx_busy = 1'b0;
    @(negedge clk_50);
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL single_en_after got %b exp 0", tx_en); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data_hold got %h exp 41", tx_data); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b exp 1", fifo_empty); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_bytes [4];
    logic [7:0] d;
    bit ok;
    exp_bytes[0] = 8'h10; exp_bytes[1] = 8'h20; exp_bytes[2] = 8'h11; exp_bytes[3] = 8'h21;
    apply_reset();
    req0_valid = 1'b1; req0_data = 8'h10; req1_valid = 1'b1; req1_data = 8'h20;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rr_grant0 got %b exp 10", {req0_ready, req1_ready}); end
    @(negedge clk_50);
    req0_data = 8'h11;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL rr_grant1 got %b exp 01", {req0_ready, req1_ready}); end
    @(negedge clk_50);
    req1_data = 8'h21;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rr_grant2 got %b exp 10", {req0_ready, req1_ready}); end
    @(negedge clk_50);
    req0_valid = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rr_grant3 got %b exp 1", req1_ready); end
    @(negedge clk_50);
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve_byte(d, ok);
      checks++;
      if (!ok || d !== exp_bytes[i]) begin
        errors++; $display("FAIL rr_order[%0d] got %h (seen %b) exp %h", i, d, ok, exp_bytes[i]);
      end
    end
  endtask

  task automatic test_full();
    logic [7:0] d;
    bit ok;
    bit got;
    tx_busy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      req1_valid = 1'b1; req1_data = 8'h80 + 8'(k);
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready[%0d] got %b exp 1", k, req1_ready); end
      @(negedge clk_50);
    end
    req1_data = 8'h89;
    #1;
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", fifo_full); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", fifo_count); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", req1_ready); end
    checks++; if (tx_data !== 8'h80) begin errors++; $display("FAIL full_head got %h exp 80", tx_data); end
    repeat (3) @(negedge clk_50);
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL full_stall_ready got %b exp 0", req1_ready); end
    tx_busy = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_50);
      if (req1_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++; if (!got) begin errors++; $display("FAIL full_accept got ready 0 exp ready 1 within 10 cycles"); end
    @(negedge clk_50);
    req1_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      serve_byte(d, ok);
      checks++;
      if (!ok || d !== 8'h81 + 8'(i)) begin
        errors++; $display("FAIL full_order[%0d] got %h (seen %b) exp %h", i, d, ok, 8'h81 + 8'(i));
      end
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL full_drained got %b exp 1", fifo_empty); end
  endtask

  task automatic test_flush();
    bit saw_en;
    tx_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_data = 8'hA0 + 8'(k);
      @(negedge clk_50);
    end
    req0_valid = 1'b0;
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", fifo_count); end
    flush = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", req0_ready); end
    @(negedge clk_50);
    flush = 1'b0;
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", fifo_empty); end
    repeat (3) @(negedge clk_50);
    tx_busy = 1'b0;
    saw_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50);
      if (tx_en !== 1'b0) saw_en = 1'b1;
    end
    checks++; if (saw_en) begin errors++; $display("FAIL flush_no_tx_en got 1 exp 0"); end
    checks++; if (tx_data !== 8'hA0) begin errors++; $display("FAIL flush_data_hold got %h exp a0", tx_data); end
  endtask

  task automatic test_reset_mid_wait();
    tx_busy = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h99;
    @(negedge clk_50);
    req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 8'h9A;
    @(negedge clk_50);
    req0_valid = 1'b0;
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL rstw_pre_en got %b exp 1", tx_en); end
    reset = 1'b1;
    @(negedge clk_50);
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL rstw_en got %b exp 0", tx_en); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstw_data got %h exp 00", tx_data); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rstw_empty got %b exp 1", fifo_empty); end
    reset = 1'b0;
    @(negedge clk_50);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rstw_rr got %b exp 10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    bit ok;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    int cnt;
    tx_busy = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h55;
    @(negedge clk_50);
    req0_data = 8'h66;
    @(negedge clk_50);
    req0_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx_en === 1'b1 && tx_data === 8'h55) cnt++;
      else break;
      @(negedge clk_50);
    end
    checks++; if (cnt != 16) begin errors++; $display("FAIL to_en_cycles got %0d exp 16", cnt); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL to_en_drop got %b exp 0", tx_en); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", timeout_err); end
    serve_byte(d, ok);
    checks++; if (!ok || d !== 8'h66) begin errors++; $display("FAIL to_next got %h (seen %b) exp 66", d, ok); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", timeout_err); end
    flush = 1'b1;
    @(negedge clk_50);
    flush = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_flush_clear got %b exp 0", timeout_err); end
`else
    tx_busy = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h55;
    @(negedge clk_50);
    req0_valid = 1'b0;
    repeat (40) @(negedge clk_50);
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL nto_wait_en got %b exp 1", tx_en); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL nto_err got %b exp 0", timeout_err); end
    serve_byte(d, ok);
    checks++; if (!ok || d !== 8'h55) begin errors++; $display("FAIL nto_byte got %h (seen %b) exp 55", d, ok); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_flush();
    test_reset_mid_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
